// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi link: code defaults, encoder FSM states and
// the generator parity helper used by both encoder and decoder branch-metric logic.
package viterbi_pkg;

    localparam int         K_DEFAULT         = 3;
    localparam logic [2:0] G0_DEFAULT        = 3'b111;
    localparam logic [2:0] G1_DEFAULT        = 3'b101;
    localparam int         FRAME_LEN_DEFAULT = 256;

    // Widest window the parity helper accepts; callers zero-extend.
    localparam int K_MAX = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FLUSH = 2'd2
    } enc_state_t;

    function automatic logic parity(input logic [K_MAX-1:0] w, input logic [K_MAX-1:0] g);
        return ^(w & g);
    endfunction

endpackage

// File: rtl/conv_core.sv
// Feed-forward convolutional core: K-1 bit shift register plus two generator parities.
// The symbol is combinational from the current register and the incoming bit u.
module conv_core
    import viterbi_pkg::*;
#(
    parameter int         K  = K_DEFAULT,
    parameter logic [K-1:0] G0 = G0_DEFAULT,
    parameter logic [K-1:0] G1 = G1_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       shift_en,
    input  logic       u,
    output logic [1:0] sym
);

    logic [K-2:0] sr;  // sr[0] is the newest past bit
    logic [K-1:0] w;   // w[K-1] = u, w[0] = oldest past bit

    // NOTE: every combinational output gets a default before any conditional
    // or loop assignment, so no path can leave it unassigned and infer a latch.
    always_comb begin
        w      = '0;
        w[K-1] = u;
        for (int i = 0; i < K - 1; i++) begin
            w[K-2-i] = sr[i];
        end
    end

    assign sym = {parity(K_MAX'(w), K_MAX'(G0)), parity(K_MAX'(w), K_MAX'(G1))};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (shift_en) begin
            sr <= (K-1)'({sr, u});
        end
    end

endmodule

// File: rtl/conv_encoder_framer.sv
// Rate-1/2 convolutional encoder with zero-tail frame termination and frame markers.
// Accepts FRAME_LEN info bits, then flushes K-1 zero bits so each frame ends in state 0.
module conv_encoder_framer
    import viterbi_pkg::*;
#(
    parameter int           K         = K_DEFAULT,
    parameter logic [K-1:0] G0        = G0_DEFAULT,
    parameter logic [K-1:0] G1        = G1_DEFAULT,
    parameter int           FRAME_LEN = FRAME_LEN_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic       d_in,
    output logic       ready_o,
    output logic       valid_o,
    output logic [1:0] d_out,
    output logic       frame_start_o,
    output logic       frame_end_o
);

    localparam int BW = $clog2(FRAME_LEN + 1);
    localparam int TW = $clog2(K);
    localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_LEN);
    localparam logic [TW-1:0] TAIL_LAST = TW'(K - 2);

    enc_state_t    state, state_n;
    logic [BW-1:0] bit_ct, bit_ct_n;
    logic [TW-1:0] tail_ct, tail_ct_n;
    logic          accept, emit, u;
    logic          frame_start_n, frame_end_n;
    logic [1:0]    sym;

    // ready_o depends on state only, so the upstream source sees no enable_i loop.
    assign ready_o = (state != FLUSH);
    assign accept  = enable_i && ready_o;
    assign emit    = accept || (state == FLUSH);
    assign u       = (state == FLUSH) ? 1'b0 : d_in;

    conv_core #(
        .K  (K),
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .shift_en (emit),
        .u        (u),
        .sym      (sym)
    );

    always_comb begin
        state_n       = state;
        bit_ct_n      = bit_ct;
        tail_ct_n     = tail_ct;
        frame_start_n = 1'b0;
        frame_end_n   = 1'b0;
        unique case (state)
            // IDLE and DATA differ only in marking the first symbol; bit_ct is 0 in IDLE.
            IDLE, DATA: begin
                if (accept) begin
                    bit_ct_n      = bit_ct + 1'b1;
                    frame_start_n = (state == IDLE);
                    state_n       = (bit_ct_n == BIT_LAST) ? FLUSH : DATA;
                end
            end
            FLUSH: begin
                if (tail_ct == TAIL_LAST) begin
                    tail_ct_n   = '0;
                    bit_ct_n    = '0;
                    frame_end_n = 1'b1;
                    state_n     = IDLE;
                end else begin
                    tail_ct_n = tail_ct + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bit_ct        <= '0;
            tail_ct       <= '0;
            valid_o       <= 1'b0;
            d_out         <= 2'b00;
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
        end else begin
            state         <= state_n;
            bit_ct        <= bit_ct_n;
            tail_ct       <= tail_ct_n;
            valid_o       <= emit;
            d_out         <= emit ? sym : 2'b00;
            frame_start_o <= frame_start_n;
            frame_end_o   <= frame_end_n;
        end
    end

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Self-checking bench: convolution-sum reference model compared every cycle,
// plus literal symbol sequences for directed frames and a FRAME_LEN=1 instance.
module tb_conv_encoder_framer;
    import viterbi_pkg::*;

    localparam int       KK = 3;
    localparam int       FL = 4;
    localparam int       SYMS_PER_FRAME = FL + KK - 1;
    localparam bit [2:0] GEN0 = 3'b111;
    localparam bit [2:0] GEN1 = 3'b101;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable_i = 1'b0, d_in = 1'b0;
    logic       ready_o, valid_o, frame_start_o, frame_end_o;
    logic [1:0] d_out;

    logic       en2 = 1'b0, d2 = 1'b0;
    logic       ready2, valid2, fs2, fe2;
    logic [1:0] dout2;

    always #5 clk = ~clk;

    conv_encoder_framer #(.K(KK), .G0(GEN0), .G1(GEN1), .FRAME_LEN(FL)) u_dut (
        .clk(clk), .rst(rst), .enable_i(enable_i), .d_in(d_in),
        .ready_o(ready_o), .valid_o(valid_o), .d_out(d_out),
        .frame_start_o(frame_start_o), .frame_end_o(frame_end_o)
    );

    conv_encoder_framer #(.K(KK), .G0(GEN0), .G1(GEN1), .FRAME_LEN(1)) u_dut1 (
        .clk(clk), .rst(rst), .enable_i(en2), .d_in(d2),
        .ready_o(ready2), .valid_o(valid2), .d_out(dout2),
        .frame_start_o(fs2), .frame_end_o(fe2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the current frame's bit sequence (info then tail zeros);
    // each symbol is the convolution of the generators with that sequence.
    bit         frame_q[$];
    int         tail_left = 0;
    bit         chk_on = 1'b0;
    logic       exp_valid = 1'b0, exp_fs = 1'b0, exp_fe = 1'b0, exp_ready = 1'b1;
    logic [1:0] exp_dout = 2'b00;

    function automatic logic [1:0] encode_last();
        int n = frame_q.size() - 1;
        bit p1 = 1'b0, p0 = 1'b0;
        for (int j = 0; j < KK; j++) begin
            if (n - j >= 0) begin
                p1 ^= GEN0[KK-1-j] & frame_q[n-j];
                p0 ^= GEN1[KK-1-j] & frame_q[n-j];
            end
        end
        return {p1, p0};
    endfunction

    task automatic model_edge(input bit r, input bit en, input bit d);
        exp_valid = 1'b0; exp_dout = 2'b00; exp_fs = 1'b0; exp_fe = 1'b0;
        if (r) begin
            frame_q.delete();
            tail_left = 0;
        end else if (tail_left > 0) begin
            frame_q.push_back(1'b0);
            exp_valid = 1'b1;
            exp_dout  = encode_last();
            tail_left--;
            if (tail_left == 0) begin
                exp_fe = 1'b1;
                frame_q.delete();
            end
        end else if (en) begin
            exp_fs = (frame_q.size() == 0);
            frame_q.push_back(d);
            exp_valid = 1'b1;
            exp_dout  = encode_last();
            if (frame_q.size() == FL) tail_left = KK - 1;
        end
        exp_ready = (tail_left == 0);
    endtask

    // Observed symbols and flags, for literal sequence checks.
    logic [1:0] got_sym[$];
    bit         got_fs[$], got_fe[$];
    int         low_cnt = 0;
    logic [1:0] got2_sym[$];
    bit         got2_fs[$], got2_fe[$];
    int         low2_cnt = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            check("valid_o", valid_o, exp_valid);
            check("d_out", d_out, exp_dout);
            check("frame_start_o", frame_start_o, exp_fs);
            check("frame_end_o", frame_end_o, exp_fe);
            check("ready_o", ready_o, exp_ready);
            if (valid_o === 1'b1) begin
                got_sym.push_back(d_out);
                got_fs.push_back(frame_start_o);
                got_fe.push_back(frame_end_o);
            end
            if (ready_o === 1'b0) low_cnt++;
            if (valid2 === 1'b1) begin
                got2_sym.push_back(dout2);
                got2_fs.push_back(fs2);
                got2_fe.push_back(fe2);
            end
            if (ready2 === 1'b0) low2_cnt++;
        end
    end

    task automatic step(input bit r, input bit en, input bit d);
        rst = r; enable_i = en; d_in = d;
        @(posedge clk);
        model_edge(r, en, d);
        if (r) chk_on = 1'b1;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic clear_got();
        got_sym.delete(); got_fs.delete(); got_fe.delete();
        low_cnt = 0;
    endtask

    logic [1:0] exp_q[$];

    task automatic check_got(input string nm);
        check({nm, "_count"}, got_sym.size(), exp_q.size());
        for (int i = 0; i < got_sym.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_sym%0d", nm, i), got_sym[i], exp_q[i]);
            check($sformatf("%s_fs%0d", nm, i), got_fs[i], (i % SYMS_PER_FRAME) == 0);
            check($sformatf("%s_fe%0d", nm, i), got_fe[i], (i % SYMS_PER_FRAME) == SYMS_PER_FRAME - 1);
        end
    endtask

    task automatic send_1000();
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        // Reset held two cycles, then released.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("rst_valid", valid_o, 1'b0);
        check("rst_dout", d_out, 2'b00);
        check("rst_ready", ready_o, 1'b1);
        check("rst_flags", {frame_start_o, frame_end_o}, 2'b00);

        // Single 1 followed by zeros: impulse response then tail.
        clear_got();
        send_1000();
        idle(4);
        exp_q = '{2'd3, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
        check_got("s2");
        check("s2_ready_low", low_cnt, 2);

        // All ones.
        clear_got();
        repeat (4) step(1'b0, 1'b1, 1'b1);
        idle(4);
        exp_q = '{2'd3, 2'd1, 2'd2, 2'd2, 2'd1, 2'd3};
        check_got("s3");
        check("s3_sr_zero", u_dut.u_core.sr, 2'b00);
        check("s3_state_idle", u_dut.state, IDLE);

        // Same data as the impulse frame with enable gaps of 1 and 3 cycles.
        clear_got();
        step(1'b0, 1'b1, 1'b1);
        idle(1);
        step(1'b0, 1'b1, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(4);
        exp_q = '{2'd3, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
        check_got("s4");

        // enable held high 12 cycles: two back-to-back frames, tails non-accepting.
        clear_got();
        repeat (12) step(1'b0, 1'b1, 1'b1);
        idle(3);
        exp_q = '{2'd3, 2'd1, 2'd2, 2'd2, 2'd1, 2'd3,
                  2'd3, 2'd1, 2'd2, 2'd2, 2'd1, 2'd3};
        check_got("s5");
        check("s5_ready_low", low_cnt, 4);

        // Reset mid-frame, then the impulse frame must reproduce exactly.
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("s6_valid_after_rst", valid_o, 1'b0);
        check("s6_state_idle", u_dut.state, IDLE);
        clear_got();
        send_1000();
        idle(4);
        exp_q = '{2'd3, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
        check_got("s6");

        // FRAME_LEN = 1 instance: one info bit, two tail symbols.
        low2_cnt = 0;
        en2 = 1'b1; d2 = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        en2 = 1'b0; d2 = 1'b0;
        idle(4);
        check("fl1_count", got2_sym.size(), 3);
        if (got2_sym.size() == 3) begin
            check("fl1_sym0", got2_sym[0], 2'd3);
            check("fl1_sym1", got2_sym[1], 2'd2);
            check("fl1_sym2", got2_sym[2], 2'd3);
            check("fl1_fs", {got2_fs[0], got2_fs[1], got2_fs[2]}, 3'b100);
            check("fl1_fe", {got2_fe[0], got2_fe[1], got2_fe[2]}, 3'b001);
        end
        check("fl1_ready_low", low2_cnt, 2);

        // Randomized traffic with occasional resets, checked every cycle by the model.
        repeat (600) begin
            step(1'($urandom_range(0, 99) == 0),
                 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 1)));
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
